// File: rtl/mips_rf_pkg.sv
// mips_rf_pkg: register file defaults and named MIPS register indices
package mips_rf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO = 0;
  localparam int REG_AT = 1;
  localparam int REG_V0 = 2;
  localparam int REG_V1 = 3;
  localparam int REG_A0 = 4;
  localparam int REG_T0 = 8;
  localparam int REG_S0 = 16;
  localparam int REG_GP = 28;
  localparam int REG_SP = 29;
  localparam int REG_FP = 30;
  localparam int REG_RA = 31;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write bits, issue gating, per-port busy and pending count
import mips_rf_pkg::*;
module rf_scoreboard #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic set, clr, inc, dec;
  always_comb begin
    iss_ready = !busy_q[iss_addr] || (wr_en && wr_addr == iss_addr) || iss_addr == ZERO;
    set = iss_en && iss_ready && iss_addr != ZERO;
    clr = wr_en && wr_addr != ZERO;
    inc = set && !busy_q[iss_addr];
    dec = clr && busy_q[wr_addr] && !(set && iss_addr == wr_addr);
    busy_d = busy_q;
    if (clr) busy_d[wr_addr] = 1'b0;
    if (set) busy_d[iss_addr] = 1'b1;
    cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy_cnt = cnt_q;
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_busy[i] = busy_q[a] && !(wr_en && wr_addr == a);
  end
endmodule

// File: rtl/mips_regfile_sb.sv
// mips_regfile_sb: multi-port MIPS register file with write bypass and pending-write scoreboard
import mips_rf_pkg::*;
module mips_regfile_sb #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  always_comb begin
    mem_d = mem_q;
    if (wr_en && wr_addr != ZERO) mem_d[wr_addr] = wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_data[i*DATA_W +: DATA_W] = a == ZERO ? '0 : (wr_en && wr_addr == a) ? wr_data : mem_q[a];
  end
  rf_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_sb (
    .clk(clk),
    .rst(rst),
    .rd_addr(rd_addr),
    .rd_busy(rd_busy),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .iss_en(iss_en),
    .iss_addr(iss_addr),
    .iss_ready(iss_ready),
    .busy_cnt(busy_cnt)
  );
endmodule

// File: tb/tb_mips_regfile_sb.sv
// tb_mips_regfile_sb: directed and randomized checks of the register file against a behavioural model
module tb_mips_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int DEPTH = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_busy;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic iss_en = 1'b0;
  logic [AW-1:0] iss_addr = '0;
  logic iss_ready;
  logic [AW:0] busy_cnt;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DEPTH-1:0] m_busy = '0;
  bit chk_en = 1'b0;
  bit acc;
  always #5 clk = ~clk;
  mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk),
    .rst(rst),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_busy(rd_busy),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .iss_en(iss_en),
    .iss_addr(iss_addr),
    .iss_ready(iss_ready),
    .busy_cnt(busy_cnt)
  );
  task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction
  function automatic logic m_rbusy(input logic [AW-1:0] a);
    return m_busy[a] && !(wr_en && wr_addr == a);
  endfunction
  function automatic logic m_ready();
    return !m_busy[iss_addr] || (wr_en && wr_addr == iss_addr) || iss_addr == 0;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_busy = '0;
      chk_en = 1'b1;
    end else begin
      acc = iss_en && m_ready();
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (wr_en) m_busy[wr_addr] = 1'b0;
      if (acc && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NR; p++) begin
        expect_eq($sformatf("model rd_data%0d", p), 64'(rd_data[p*DW +: DW]), 64'(m_read(rd_addr[p*AW +: AW])));
        expect_eq($sformatf("model rd_busy%0d", p), 64'(rd_busy[p]), 64'(m_rbusy(rd_addr[p*AW +: AW])));
      end
      expect_eq("model iss_ready", 64'(iss_ready), 64'(m_ready()));
      expect_eq("model busy_cnt", 64'(busy_cnt), 64'($countones(m_busy)));
    end
  end
  task automatic idle();
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    iss_en = 1'b0;
    iss_addr = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd4(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    rd_addr = {a3, a2, a1, a0};
    #1;
  endtask
  function automatic logic [AW-1:0] rnd_a();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
  endfunction
  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      rd4(AW'(a), AW'(a), AW'(a), AW'(a));
      expect_eq("reset rd_data0", 64'(rd_data[0 +: DW]), 64'h0);
      expect_eq("reset rd_data1", 64'(rd_data[DW +: DW]), 64'h0);
      expect_eq("reset rd_busy", 64'(rd_busy), 64'h0);
      expect_eq("reset iss_ready", 64'(iss_ready), 64'h1);
      expect_eq("reset busy_cnt", 64'(busy_cnt), 64'h0);
    end
    tick();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    rd4(5'd5, 5'd0, 5'd0, 5'd0);
    expect_eq("bypass r5", 64'(rd_data[0 +: DW]), 64'hDEADBEEF);
    tick();
    idle();
    rd4(5'd5, 5'd0, 5'd0, 5'd0);
    expect_eq("stored r5", 64'(rd_data[0 +: DW]), 64'hDEADBEEF);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    rd4(5'd0, 5'd0, 5'd0, 5'd0);
    expect_eq("r0 bypass", 64'(rd_data[0 +: DW]), 64'h0);
    tick();
    idle();
    rd4(5'd0, 5'd0, 5'd0, 5'd0);
    expect_eq("r0 stored", 64'(rd_data[0 +: DW]), 64'h0);
    iss_en = 1'b1; iss_addr = 5'd8;
    tick();
    idle();
    rd4(5'd8, 5'd0, 5'd0, 5'd0);
    expect_eq("r8 busy", 64'(rd_busy[0]), 64'h1);
    expect_eq("cnt after r8", 64'(busy_cnt), 64'h1);
    iss_en = 1'b1; iss_addr = 5'd8;
    #1;
    expect_eq("reissue r8 ready", 64'(iss_ready), 64'h0);
    tick();
    expect_eq("cnt after reissue", 64'(busy_cnt), 64'h1);
    iss_en = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h80;
    #1;
    expect_eq("wb r8 busy", 64'(rd_busy[0]), 64'h0);
    expect_eq("wb r8 data", 64'(rd_data[0 +: DW]), 64'h80);
    expect_eq("wb r8 ready", 64'(iss_ready), 64'h1);
    tick();
    idle();
    #1;
    expect_eq("cnt after wb r8", 64'(busy_cnt), 64'h0);
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    iss_en = 1'b1; iss_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    tick();
    idle();
    rd4(5'd9, 5'd0, 5'd0, 5'd0);
    expect_eq("r9 set wins", 64'(rd_busy[0]), 64'h1);
    expect_eq("r9 data", 64'(rd_data[0 +: DW]), 64'h99);
    expect_eq("cnt r9", 64'(busy_cnt), 64'h1);
    iss_en = 1'b1; iss_addr = 5'd11;
    tick();
    expect_eq("cnt r11", 64'(busy_cnt), 64'h2);
    iss_en = 1'b1; iss_addr = 5'd10;
    wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'hB;
    tick();
    idle();
    #1;
    expect_eq("cnt net zero", 64'(busy_cnt), 64'h2);
    wr_en = 1'b1; wr_addr = 5'd9;
    tick();
    wr_addr = 5'd10;
    tick();
    idle();
    #1;
    expect_eq("cnt cleared", 64'(busy_cnt), 64'h0);
    for (int a = 1; a < DEPTH; a++) begin
      iss_en = 1'b1; iss_addr = AW'(a);
      tick();
    end
    idle();
    #1;
    expect_eq("cnt full", 64'(busy_cnt), 64'd31);
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    tick();
    rst = 1'b0;
    idle();
    rd4(5'd3, 5'd1, 5'd31, 5'd8);
    expect_eq("rst cnt", 64'(busy_cnt), 64'h0);
    expect_eq("rst r3", 64'(rd_data[0 +: DW]), 64'h0);
    expect_eq("rst busy", 64'(rd_busy), 64'h0);
    wr_en = 1'b1;
    wr_addr = 5'd12; wr_data = 32'hA1A1;
    tick();
    wr_addr = 5'd13; wr_data = 32'hB2B2;
    tick();
    wr_addr = 5'd14; wr_data = 32'hC3C3;
    tick();
    wr_addr = 5'd15; wr_data = 32'hD4D4;
    rd4(5'd12, 5'd13, 5'd14, 5'd15);
    expect_eq("quad p0", 64'(rd_data[0 +: DW]), 64'hA1A1);
    expect_eq("quad p1", 64'(rd_data[DW +: DW]), 64'hB2B2);
    expect_eq("quad p2", 64'(rd_data[2*DW +: DW]), 64'hC3C3);
    expect_eq("quad p3", 64'(rd_data[3*DW +: DW]), 64'hD4D4);
    tick();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = rnd_a();
      wr_data = $urandom;
      iss_en = ($urandom_range(0, 3) != 0);
      iss_addr = rnd_a();
      rd_addr = {rnd_a(), rnd_a(), rnd_a(), rnd_a()};
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_regfile_sb.md
# mips_regfile_sb

Parametrised multi-read-port register file for the MIPS core with a per-register pending-write scoreboard. It serves the decode stage with combinational reads, including same-cycle write-to-read bypass. It accepts one writeback per cycle, and tracks registers targeted by issued long-latency operations (loads, mult/div) so decode can stall on RAW/WAW hazards. Register 0 is hardwired to zero. Writes are edge-triggered.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port i's register has an outstanding pending write
- wr_en  in  1  writeback valid
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback value
- iss_en  in  1  issue request: mark iss_addr pending
- iss_addr  in  ADDR_W  destination of the issued long-latency operation
- iss_ready  out  1  issue can be accepted this cycle
- busy_cnt  out  ADDR_W+1  number of registers currently pending

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits. Entry 0 is not stored; it always reads 0.
- Write: on a rising edge with wr_en=1 and wr_addr≠0, the entry takes wr_data. A write to 0 is discarded.
- Read port i, combinational:
  - If rd_addr_i=0, the port returns 0.
  - Else if wr_en=1 and wr_addr=rd_addr_i, the port returns wr_data (bypass).
  - Else the port returns the stored entry.
- Scoreboard: one busy bit per entry; bit 0 is constantly 0.
  - Accepted issue (iss_en & iss_ready) with iss_addr≠0 sets busy[iss_addr] at the edge. An accepted issue to address 0 changes nothing.
  - wr_en=1 clears busy[wr_addr] at the edge. A writeback to a non-pending register is legal, writes data, and leaves busy unchanged.
  - Simultaneous set and clear of the same address: the set wins, so the bit stays 1. This is a new producer replacing an old one.
- iss_ready = !busy[iss_addr] OR (wr_en & wr_addr=iss_addr) OR iss_addr=0. This blocks WAW on a register with an unresolved producer.
- iss_en=1 while iss_ready=0 is ignored. Nothing is queued; the caller holds the request.
- rd_busy_i = busy[rd_addr_i] AND NOT (wr_en & wr_addr=rd_addr_i). The bypass resolves the hazard in the same cycle.
- busy_cnt equals the population count of the busy bits. It is updated as a registered counter: +1 on a set of a clear bit, −1 on a clear of a set bit, and net 0 when both occur on different addresses.
- Reset: all entries 0, all busy bits 0, busy_cnt 0. Writes and issues presented during the reset cycle are dropped.

## Timing
- Read latency 0 (combinational from rd_addr, wr_* and state).
- Write latency 1: a value written at edge N is visible from storage after edge N, and via bypass during the cycle before edge N.
- Busy bit latency 1: an issue accepted at edge N makes rd_busy high from cycle N+1. A writeback in cycle M drops rd_busy combinationally in cycle M.
- iss_ready is combinational. There is no combinational path from iss_en to any output.
- Reset values after the reset edge:
  - rd_data = 0 for every address.
  - rd_busy = 0.
  - iss_ready = 1.
  - busy_cnt = 0.
- Reset asserted mid-operation overrides any concurrent write or issue. Pending state is lost, and the pipeline flush upstream owns recovery.
- Maximum busy_cnt = 2**ADDR_W − 1. The counter cannot overflow because its width is ADDR_W+1.

## Structure
- Shared package mips_rf_pkg holds:
  - default DATA_W and ADDR_W
  - REG_ZERO = 0
  - named register indices (REG_SP = 29, REG_RA = 31, etc.) used by the core and the benches
- One sub-module: rf_scoreboard (busy bits, iss_ready, rd_busy, busy_cnt), parametrised by ADDR_W and NUM_RD.
- The top level holds storage, bypass muxes and the generate loop over read ports.

## Test plan
- Reset then read all 32 addresses on both ports → all 0, rd_busy=0, iss_ready=1, busy_cnt=0.
- Write 0xDEADBEEF to r5 with rd_addr0=5 in the same cycle → rd_data0=0xDEADBEEF in that cycle; from the next cycle, storage read also returns 0xDEADBEEF. Write 0x1234 to r0 → r0 still reads 0.
- Issue r8, next cycle read r8 → rd_busy0=1, busy_cnt=1. Re-issue r8 → iss_ready=0, busy_cnt stays 1. Writeback r8=0x80 → in that cycle rd_busy0=0, rd_data0=0x80, iss_ready=1. Next cycle busy_cnt=0.
- Same cycle: writeback r9 and issue r9 → after the edge busy[9]=1, r9=written data, busy_cnt unchanged. Same cycle: issue r10 and writeback pending r11 → busy_cnt net unchanged.
- Issue r1..r31 on consecutive cycles → busy_cnt=31. Assert rst for one cycle with concurrent wr_en to r3 → busy_cnt=0, r3=0, all rd_busy=0.
- NUM_RD=4 build: four distinct addresses read in one cycle, one of them bypassed → all four values correct.
